// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues held-until-ready requests to
// instruction memory and presents {pc_out, inst, fetch_valid} to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_write,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  if_fetch_unit_if.master       im,
  output logic [31:0]           pc_out,
  output logic [31:0]           inst,
  output logic                  fetch_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    KILL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic [31:0] tgt;
  logic [31:0] seq_addr;
  logic        hit;
  logic        hold_out;

  assign tgt      = branch_target & ~32'h3;
  assign seq_addr = req_addr_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_buf_d = inst_buf_q;
    unique case (state_q)
      FETCH: begin
        if (im.im_ready) begin
          if (branch_taken) begin
            pc_d       = tgt;
            req_addr_d = tgt;
          end else if (pc_write) begin
            pc_d       = seq_addr;
            req_addr_d = seq_addr;
          end else begin
            inst_buf_d = im.im_rdata;
            state_d    = HOLD;
          end
        end else if (branch_taken) begin
          // Request in flight cannot be abandoned: park the target in pc and
          // keep req_addr on the stale address until memory answers.
          pc_d    = tgt;
          state_d = KILL;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = FETCH;
        end else if (pc_write) begin
          pc_d       = seq_addr;
          req_addr_d = seq_addr;
          state_d    = FETCH;
        end
      end
      KILL: begin
        if (branch_taken) begin
          pc_d = tgt;
        end
        if (im.im_ready) begin
          req_addr_d = branch_taken ? tgt : pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_buf_q <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  // rst gates im_req so the request drops the instant reset asserts.
  assign im.im_req  = rst && (state_q != HOLD);
  assign im.im_addr = req_addr_q;
  assign pc_out     = req_addr_q;

  assign hit      = rst && (state_q == FETCH) && im.im_ready && !branch_taken;
  assign hold_out = rst && (state_q == HOLD) && !branch_taken;

  assign fetch_valid = hit || hold_out;

  always_comb begin
    inst = NOP_INST;
    if (hit) begin
      inst = im.im_rdata;
    end else if (hold_out) begin
      inst = inst_buf_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against a fetch-stream reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] inst;
  logic        fetch_valid;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .im            (bus),
    .pc_out        (pc_out),
    .inst          (inst),
    .fetch_valid   (fetch_valid)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: the architectural next PC, the address currently on the
  // memory bus, whether a fetched word is waiting for IF/ID to accept it, and
  // whether the word in flight belongs to a squashed path.
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_held;
  logic [31:0] m_word;
  logic        m_stale;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_addr  = RESET_PC;
    m_held  = 1'b0;
    m_word  = NOP;
    m_stale = 1'b0;
  endtask

  // Called just after a rising edge; drives one cycle, checks before the next edge.
  task automatic step(input logic pw, input logic br, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd);
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] aligned;
    pc_write      = pw;
    branch_taken  = br;
    branch_target = tgt;
    bus.im_ready  = rdy;
    bus.im_rdata  = rd;
    #3;
    aligned = {tgt[31:2], 2'b00};
    if (m_held) begin
      e_valid = !br;
      e_inst  = br ? NOP : m_word;
    end else if (!m_stale && rdy && !br) begin
      e_valid = 1'b1;
      e_inst  = rd;
    end else begin
      e_valid = 1'b0;
      e_inst  = NOP;
    end
    chk("im_req", {31'd0, bus.im_req}, {31'd0, !m_held});
    if (!m_held) chk("im_addr", bus.im_addr, m_addr);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_valid});
    chk("inst", inst, e_inst);
    if (e_valid) chk("pc_out", pc_out, m_addr);

    if (br) begin
      m_pc = aligned;
      if (m_held || rdy) begin
        m_addr  = aligned;
        m_held  = 1'b0;
        m_stale = 1'b0;
      end else begin
        m_stale = 1'b1;
      end
    end else if (m_held) begin
      if (pw) begin
        m_pc   = m_addr + 32'd4;
        m_addr = m_pc;
        m_held = 1'b0;
      end
    end else if (rdy) begin
      if (m_stale) begin
        m_addr  = m_pc;
        m_stale = 1'b0;
      end else if (pw) begin
        m_pc   = m_addr + 32'd4;
        m_addr = m_pc;
      end else begin
        m_held = 1'b1;
        m_word = rd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    pc_write      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    bus.im_ready  = 1'b1;
    bus.im_rdata  = 32'hDEAD_BEEF;
    model_reset();

    // Reset state, with im_ready held high to show it is ignored.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_im_req", {31'd0, bus.im_req}, 32'd0);
    chk("rst_im_addr", bus.im_addr, RESET_PC);
    chk("rst_pc_out", pc_out, RESET_PC);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    rst = 1'b1;

    // Back-to-back hits from reset: 0, 4, 8, C.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);

    // Three wait cycles on 0x10, then the hit.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, $urandom);
    chk("slow_addr", bus.im_addr, 32'h10);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_0010);

    // 0x14..0x1C, then hit on 0x20 while stalled, held for another cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    chk("hold_addr", bus.im_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("after_hold_addr", bus.im_addr, 32'h24);

    // Advance to 0x40, redirect to 0x103 while that request is pending.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    chk("pend_addr", bus.im_addr, 32'h40);
    step(1'b1, 1'b1, 32'h103, 1'b0, 32'h0);
    chk("kill_addr", bus.im_addr, 32'h40);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0040);
    chk("redirect_addr", bus.im_addr, 32'h100);

    // Hit on 0x100 into HOLD, then branch in HOLD with pc_write low.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    chk("wrap_start", bus.im_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hCAFE_FFFC);
    chk("wrap_addr", bus.im_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of a pending request.
    pc_write     = 1'b1;
    branch_taken = 1'b0;
    bus.im_ready = 1'b0;
    #2;
    chk("pre_rst_req", {31'd0, bus.im_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, bus.im_req}, 32'd0);
    chk("async_rst_addr", bus.im_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_pw;
      logic        r_br;
      logic        r_rdy;
      logic [31:0] r_tgt;
      r_pw  = ($urandom_range(0, 9) < 7);
      r_br  = ($urandom_range(0, 9) == 0);
      r_rdy = ($urandom_range(0, 9) < 6);
      r_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(r_pw, r_br, r_tgt, r_rdy, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
